// File: rtl/dout_rails_pkg.sv
// dout_rails_pkg: shared definitions for the digital-output rail scheduling
// blocks. Holds the sequencer state encoding, the "no rail selected" code,
// rail code field widths and the default timing parameters.
package dout_rails_pkg;

  localparam int unsigned RAIL_FIELD_W        = 2;                  // one rail selector field
  localparam int unsigned RAIL_CODE_W         = 2 * RAIL_FIELD_W;   // [3:2] bottom, [1:0] top
  localparam int unsigned BANK_IDX_W          = 3;                  // bus bank index width
  localparam int unsigned WAIT_EXP_DEFAULT    = 17;                 // 2^17 > controller delay 2^16+2
  localparam int unsigned ACK_TIMEOUT_DEFAULT = 15;

  localparam logic [RAIL_CODE_W-1:0] RAIL_CODE_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/dig_out_rail_sequencer_if.sv
// dig_out_rail_sequencer_if: bus-decoder side of the rail sequencer.
//   wr_strobe : one-cycle write pulse
//   wr_bank   : target bank of the write
//   wr_data   : rail code, [3:2] bottom rail, [1:0] top rail
//   rd_bank   : read-back bank select
//   rd_data   : requested rail code of rd_bank (4'hF when out of range)
// master = bus decoder, slave = sequencer.
interface dig_out_rail_sequencer_if;
  import dout_rails_pkg::*;

  logic                   wr_strobe;
  logic [BANK_IDX_W-1:0]  wr_bank;
  logic [RAIL_CODE_W-1:0] wr_data;
  logic [BANK_IDX_W-1:0]  rd_bank;
  logic [RAIL_CODE_W-1:0] rd_data;

  modport master (output wr_strobe, wr_bank, wr_data, rd_bank, input  rd_data);
  modport slave  (input  wr_strobe, wr_bank, wr_data, rd_bank, output rd_data);
endinterface

// File: rtl/dig_out_rail_sequencer_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   : request vector, one bit per requester
//   last  : index of the most recently served requester
//   valid : at least one request is set
//   idx   : first set request scanning upward from last+1, wrapping mod N
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // k = scan distance from last; the inner loop only maps distance to a
    // constant bit position so req is never indexed by a variable.
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!valid && req[j] && (j == ((32'(last) + k) % N))) begin
          valid = 1'b1;
          idx   = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dig_out_rail_sequencer.sv
// dig_out_rail_sequencer: serialises rail-voltage changes across the
// digital-output banks so only one bank's rail switches are in transition
// at a time. Each bank has a bus-written requested code and an applied code;
// pending banks are granted round-robin, each grant runs a start/ack
// handshake followed by a 2^WAIT_EXP+1 cycle settle wait.
//
// Ports:
//   xclk, reset            : clock, asynchronous active-low reset
//   bus                    : bus decoder write/read-back (slave modport)
//   stored_bank_rails      : applied code per bank, bank i at [4i+3:4i]
//   rail_change_start      : registered per-bank start strobe (at most one-hot)
//   rail_change_ack        : per-bank ack from the rail controllers
//   pending                : bank has an unapplied request
//   busy                   : sequencer not idle
//   ack_err                : sticky per-bank ack-timeout flag
//
// Build option: RAIL_SEQ_ACK_TIMEOUT_EN enables the ISSUE ack timeout
// (ACK_TIMEOUT cycles) and ack_err; without it ack_err is tied low.
module dig_out_rail_sequencer
  import dout_rails_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned WAIT_EXP    = WAIT_EXP_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                               xclk,
  input  logic                               reset,
  dig_out_rail_sequencer_if.slave            bus,
  output logic [RAIL_CODE_W*NUM_BANKS-1:0]   stored_bank_rails,
  output logic [NUM_BANKS-1:0]               rail_change_start,
  input  logic [NUM_BANKS-1:0]               rail_change_ack,
  output logic [NUM_BANKS-1:0]               pending,
  output logic                               busy,
  output logic [NUM_BANKS-1:0]               ack_err
);

  localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 1);
  // One counter serves both the settle wait and the ack timeout.
  localparam int unsigned CNT_W = (WAIT_EXP + 1 > TO_W) ? WAIT_EXP + 1 : TO_W;
  localparam logic [BANK_IDX_W:0] NB_LIM = (BANK_IDX_W+1)'(NUM_BANKS);

  typedef logic [NUM_BANKS-1:0][RAIL_CODE_W-1:0] code_arr_t;

  seq_state_t             state_q, state_d;
  code_arr_t              req_q, req_d;
  code_arr_t              app_q, app_d;
  logic [NUM_BANKS-1:0]   pend_q, pend_d;
  logic [NUM_BANKS-1:0]   start_q, start_d;
  logic [BANK_IDX_W-1:0]  g_q, g_d;
  logic [BANK_IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
`ifdef RAIL_SEQ_ACK_TIMEOUT_EN
  logic [NUM_BANKS-1:0]   err_q, err_d;
`endif

  logic                   wr_hit;
  logic                   ack_g;
  logic                   pick_valid;
  logic [BANK_IDX_W-1:0]  pick_idx;

  rr_pick #(
    .N     (NUM_BANKS),
    .IDX_W (BANK_IDX_W)
  ) u_pick (
    .req   (pend_q),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign wr_hit = bus.wr_strobe && ({1'b0, bus.wr_bank} < NB_LIM);

  // Ack of the granted bank only; acks on other banks are ignored.
  always_comb begin
    ack_g = 1'b0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (g_q == BANK_IDX_W'(i)) ack_g = rail_change_ack[i];
    end
  end

  always_comb begin
    bus.rd_data = RAIL_CODE_NONE;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (bus.rd_bank == BANK_IDX_W'(i)) bus.rd_data = req_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    app_d   = app_q;
    pend_d  = pend_q;
    start_d = start_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifdef RAIL_SEQ_ACK_TIMEOUT_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          g_d     = pick_idx;
          cnt_d   = '0;
          state_d = ISSUE;
          for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (pick_idx == BANK_IDX_W'(i)) begin
              app_d[i]   = req_q[i];
              pend_d[i]  = 1'b0;
              start_d[i] = 1'b1;
            end
          end
        end
      end

      ISSUE: begin
        if (ack_g) begin
          start_d = '0;
          cnt_d   = '0;
          state_d = WAIT;
        end
`ifdef RAIL_SEQ_ACK_TIMEOUT_EN
        else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          start_d = '0;
          last_d  = g_q;
          state_d = IDLE;
          for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (g_q == BANK_IDX_W'(i)) begin
              err_d[i]  = 1'b1;
              pend_d[i] = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      WAIT: begin
        if (cnt_q[WAIT_EXP]) begin
          last_d  = g_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        start_d = '0;
        state_d = IDLE;
      end
    endcase

    // A write after the grant decision keeps the bank pending, so a write
    // coinciding with its own pick applies the old code and re-queues.
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (wr_hit && (bus.wr_bank == BANK_IDX_W'(i))) begin
        req_d[i]  = bus.wr_data;
        pend_d[i] = 1'b1;
`ifdef RAIL_SEQ_ACK_TIMEOUT_EN
        err_d[i]  = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= {NUM_BANKS{RAIL_CODE_NONE}};
      app_q   <= {NUM_BANKS{RAIL_CODE_NONE}};
      pend_q  <= '0;
      start_q <= '0;
      g_q     <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
`ifdef RAIL_SEQ_ACK_TIMEOUT_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      app_q   <= app_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef RAIL_SEQ_ACK_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign stored_bank_rails = app_q;
  assign rail_change_start = start_q;
  assign pending           = pend_q;
  assign busy              = (state_q != IDLE);
`ifdef RAIL_SEQ_ACK_TIMEOUT_EN
  assign ack_err           = err_q;
`else
  assign ack_err           = '0;
`endif

endmodule
